// File: rtl/rv_isa_pkg.sv
// Shared RISC-V ISA constants, decoded-field bundle and format classifier.
package rv_isa_pkg;

    localparam int unsigned INSTR_W = 32;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_OP32   = 7'b0111011;

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    typedef struct packed {
        logic [6:0] opcode;
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [6:0] funct7;
        logic [2:0] fmt;
        logic       illegal;
    } dec_fields_t;

    // Every legal opcode ends in 2'b11, so compressed encodings fall to ILL.
    function automatic logic [2:0] fmt_of(input logic [6:0] opc, input logic rv64_en);
        logic [2:0] f;
        f = FMT_ILL;
        case (opc)
            OP_OP:                                 f = FMT_R;
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:   f = FMT_I;
            OP_STORE:                              f = FMT_S;
            OP_BRANCH:                             f = FMT_B;
            OP_LUI, OP_AUIPC:                      f = FMT_U;
            OP_JAL:                                f = FMT_J;
            OP_IMM32:                              f = rv64_en ? FMT_I : FMT_ILL;
            OP_OP32:                               f = rv64_en ? FMT_R : FMT_ILL;
            default:                               f = FMT_ILL;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// Combinational immediate generator: format-selected, sign-extended to XLEN.
module rv_imm_gen
    import rv_isa_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:7]     instr_i,
    input  logic [2:0]      fmt_i,
    output logic [XLEN-1:0] imm_o
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = 32'd0;
        case (fmt_i)
            FMT_I: imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            FMT_S: imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            FMT_B: imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                            instr_i[11:8], 1'b0};
            FMT_U: imm32 = {instr_i[31:12], 12'd0};
            FMT_J: imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                            instr_i[30:21], 1'b0};
            default: imm32 = 32'd0;
        endcase
    end

    if (XLEN > 32) begin : g_wide
        assign imm_o = {{(XLEN-32){imm32[31]}}, imm32};
    end else begin : g_narrow
        assign imm_o = imm32[XLEN-1:0];
    end

endmodule

// File: rtl/rv_decode_stage.sv
// Registered RISC-V decode stage with one-entry skid buffer on a valid/ready interface.
module rv_decode_stage
    import rv_isa_pkg::*;
#(
    parameter int unsigned XLEN            = 32,
    parameter int unsigned RV64_OPS        = 0,
    parameter int unsigned FLUSH_KEEP_SKID = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [XLEN-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [6:0]        opcode,
    output logic [4:0]        rd,
    output logic [2:0]        funct3,
    output logic [4:0]        rs1,
    output logic [4:0]        rs2,
    output logic [6:0]        funct7,
    output logic [XLEN-1:0]   imm,
    output logic [2:0]        fmt,
    output logic              illegal
);

    localparam logic RV64_EN   = (RV64_OPS != 0) && (XLEN == 64);
    localparam logic KEEP_SKID = (FLUSH_KEEP_SKID != 0);

    dec_fields_t     new_f;
    logic [XLEN-1:0] new_imm;

    dec_fields_t     out_f_q,   out_f_d,   skid_f_q,   skid_f_d;
    logic [XLEN-1:0] out_pc_q,  out_pc_d,  skid_pc_q,  skid_pc_d;
    logic [XLEN-1:0] out_imm_q, out_imm_d, skid_imm_q, skid_imm_d;
    logic            out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    logic            in_ready_q, in_ready_d;
    logic            in_fire;

    // Decode of the incoming word; registered alongside its PC.
    always_comb begin
        new_f         = '0;
        new_f.opcode  = in_instr[6:0];
        new_f.rd      = in_instr[11:7];
        new_f.funct3  = in_instr[14:12];
        new_f.rs1     = in_instr[19:15];
        new_f.rs2     = in_instr[24:20];
        new_f.funct7  = in_instr[31:25];
        new_f.fmt     = fmt_of(in_instr[6:0], RV64_EN);
        new_f.illegal = (new_f.fmt == FMT_ILL);
    end

    rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr_i (in_instr[31:7]),
        .fmt_i   (new_f.fmt),
        .imm_o   (new_imm)
    );

    assign in_fire = in_valid & in_ready_q;

    // Output slot is refilled from the skid first so order is preserved.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_f_d      = out_f_q;
        out_pc_d     = out_pc_q;
        out_imm_d    = out_imm_q;
        skid_valid_d = skid_valid_q;
        skid_f_d     = skid_f_q;
        skid_pc_d    = skid_pc_q;
        skid_imm_d   = skid_imm_q;

        if (flush) begin
            out_valid_d = 1'b0;
            if (!KEEP_SKID) begin
                skid_valid_d = 1'b0;
            end
        end else if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_f_d      = skid_f_q;
                out_pc_d     = skid_pc_q;
                out_imm_d    = skid_imm_q;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                out_valid_d  = 1'b1;
                out_f_d      = new_f;
                out_pc_d     = in_pc;
                out_imm_d    = new_imm;
            end else begin
                out_valid_d  = 1'b0;
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_f_d     = new_f;
            skid_pc_d    = in_pc;
            skid_imm_d   = new_imm;
        end

        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_f_q      <= '0;
            out_pc_q     <= '0;
            out_imm_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_f_q     <= '0;
            skid_pc_q    <= '0;
            skid_imm_q   <= '0;
            in_ready_q   <= 1'b1;
        end else begin
            out_valid_q  <= out_valid_d;
            out_f_q      <= out_f_d;
            out_pc_q     <= out_pc_d;
            out_imm_q    <= out_imm_d;
            skid_valid_q <= skid_valid_d;
            skid_f_q     <= skid_f_d;
            skid_pc_q    <= skid_pc_d;
            skid_imm_q   <= skid_imm_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_pc    = out_pc_q;
    assign imm       = out_imm_q;
    assign opcode    = out_f_q.opcode;
    assign rd        = out_f_q.rd;
    assign funct3    = out_f_q.funct3;
    assign rs1       = out_f_q.rs1;
    assign rs2       = out_f_q.rs2;
    assign funct7    = out_f_q.funct7;
    assign fmt       = out_f_q.fmt;
    assign illegal   = out_f_q.illegal;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed bench for rv_decode_stage: RV32 instance plus an RV64 instance with RV64 opcodes.
module tb_rv_decode_stage;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // RV32 instance signals
    logic        flush, in_valid, in_ready, out_valid, out_ready, illegal;
    logic [31:0] in_instr, in_pc, out_pc, imm;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3, fmt;

    // RV64 instance signals
    logic        w_flush, w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_illegal;
    logic [31:0] w_in_instr;
    logic [63:0] w_in_pc, w_out_pc, w_imm;
    logic [6:0]  w_opcode, w_funct7;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [2:0]  w_funct3, w_fmt;

    rv_decode_stage u_dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2), .funct7(funct7),
        .imm(imm), .fmt(fmt), .illegal(illegal)
    );

    rv_decode_stage #(.XLEN(64), .RV64_OPS(1)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(w_flush),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_instr(w_in_instr), .in_pc(w_in_pc),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_pc(w_out_pc),
        .opcode(w_opcode), .rd(w_rd), .funct3(w_funct3), .rs1(w_rs1), .rs2(w_rs2),
        .funct7(w_funct7), .imm(w_imm), .fmt(w_fmt), .illegal(w_illegal)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [2:0]  fmt;
        logic [31:0] imm;
    } item_t;

    item_t stream [4];
    item_t bp     [5];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        stream[0] = '{32'h00512423, 32'h0000_0110, 3'd2, 32'h0000_0008};
        stream[1] = '{32'hFE000EE3, 32'h0000_0114, 3'd3, 32'hFFFF_FFFC};
        stream[2] = '{32'h001000EF, 32'h0000_0118, 3'd5, 32'h0000_0800};
        stream[3] = '{32'h123451B7, 32'h0000_011C, 3'd4, 32'h1234_5000};
        bp[0] = '{32'h00000000, 32'h0000_0200, 3'd7, 32'h0};
        bp[1] = '{32'h0000001B, 32'h0000_0204, 3'd7, 32'h0};
        bp[2] = '{32'hFFB10093, 32'h0000_0208, 3'd1, 32'hFFFF_FFFB};
        bp[3] = '{32'h123451B7, 32'h0000_020C, 3'd4, 32'h1234_5000};
        bp[4] = '{32'h00512423, 32'h0000_0210, 3'd2, 32'h0000_0008};

        rst_n = 1'b0;
        flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
        w_flush = 1'b0; w_in_valid = 1'b0; w_in_instr = '0; w_in_pc = '0; w_out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_fmt",       64'(fmt),       64'd0);
        check("rst_imm",       64'(imm),       64'd0);
        check("rst_pc",        64'(out_pc),    64'd0);

        // First instruction: addi x1, x2, -5
        rst_n = 1'b1;
        in_valid = 1'b1; in_instr = 32'hFFB10093; in_pc = 32'h100;
        @(negedge clk);
        check("t1_valid",  64'(out_valid), 64'd1);
        check("t1_fmt",    64'(fmt),       64'd1);
        check("t1_rd",     64'(rd),        64'd1);
        check("t1_rs1",    64'(rs1),       64'd2);
        check("t1_funct3", 64'(funct3),    64'd0);
        check("t1_imm",    64'(imm),       64'hFFFF_FFFB);
        check("t1_pc",     64'(out_pc),    64'h100);

        // Back-to-back stream
        in_instr = stream[0].instr; in_pc = stream[0].pc;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check("st_valid", 64'(out_valid), 64'd1);
            check("st_fmt",   64'(fmt),       64'(stream[k].fmt));
            check("st_imm",   64'(imm),       64'(stream[k].imm));
            check("st_pc",    64'(out_pc),    64'(stream[k].pc));
            if (k == 0) check("st_s_rs2", 64'(rs2), 64'd5);
            if (k == 2) check("st_j_rd",  64'(rd),  64'd1);
            if (k < 3) begin
                in_instr = stream[k+1].instr; in_pc = stream[k+1].pc;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("st_idle", 64'(out_valid), 64'd0);

        // Backpressure: out_ready low for cycles 1..3, continuous in_valid
        begin
            int prod = 0;
            int cons = 0;
            for (int c = 0; c < 20; c++) begin
                out_ready = !(c >= 1 && c <= 3);
                if (c == 1) check("bp_in_ready_hi", 64'(in_ready), 64'd1);
                if (c == 2) check("bp_in_ready_lo", 64'(in_ready), 64'd0);
                if (out_valid && out_ready) begin
                    if (cons < 5) begin
                        check("bp_pc",      64'(out_pc),  64'(bp[cons].pc));
                        check("bp_fmt",     64'(fmt),     64'(bp[cons].fmt));
                        check("bp_imm",     64'(imm),     64'(bp[cons].imm));
                        check("bp_illegal", 64'(illegal), 64'(bp[cons].fmt == 3'd7));
                    end else begin
                        check("bp_extra", 64'(cons), 64'd4);
                    end
                    cons++;
                end
                in_valid = (prod < 5);
                if (prod < 5) begin
                    in_instr = bp[prod].instr; in_pc = bp[prod].pc;
                    if (in_ready) prod++;
                end
                @(negedge clk);
            end
            check("bp_count", 64'(cons), 64'd5);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);

        // Flush with output and skid both occupied
        in_valid = 1'b1; in_instr = 32'hFFB10093; in_pc = 32'h300; out_ready = 1'b0;
        @(negedge clk);
        in_instr = 32'h00512423; in_pc = 32'h304;
        @(negedge clk);
        check("fl_pre_ready", 64'(in_ready),  64'd0);
        check("fl_pre_valid", 64'(out_valid), 64'd1);
        flush = 1'b1; in_instr = 32'h123451B7; in_pc = 32'h308;
        @(negedge clk);
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_ready", 64'(in_ready),  64'd1);
        check("fl_stale", 64'(out_pc),    64'h300);
        flush = 1'b0; in_instr = 32'h001000EF; in_pc = 32'h30C; out_ready = 1'b1;
        @(negedge clk);
        check("fl_next_valid", 64'(out_valid), 64'd1);
        check("fl_next_pc",    64'(out_pc),    64'h30C);
        check("fl_next_fmt",   64'(fmt),       64'd5);
        in_valid = 1'b0;
        @(negedge clk);
        check("fl_drained", 64'(out_valid), 64'd0);

        // Asynchronous reset mid-stream with output and skid occupied
        in_valid = 1'b1; in_instr = 32'hFFB10093; in_pc = 32'h400; out_ready = 1'b0;
        @(negedge clk);
        in_instr = 32'h00512423; in_pc = 32'h404;
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid", 64'(out_valid), 64'd0);
        check("ar_ready", 64'(in_ready),  64'd1);
        check("ar_pc",    64'(out_pc),    64'd0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check("ar_post1", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("ar_post2", 64'(out_valid), 64'd0);

        // RV64 instance with RV64 opcodes enabled
        w_in_valid = 1'b1; w_in_instr = 32'h0010009B; w_in_pc = 64'h8000_0000_0000_1000;
        @(negedge clk);
        check("w_addiw_fmt", 64'(w_fmt),     64'd1);
        check("w_addiw_imm", w_imm,          64'd1);
        check("w_addiw_pc",  w_out_pc,       64'h8000_0000_0000_1000);
        check("w_addiw_ill", 64'(w_illegal), 64'd0);
        w_in_instr = 32'h800000B7; w_in_pc = 64'h8000_0000_0000_1004;
        @(negedge clk);
        check("w_lui_fmt", 64'(w_fmt), 64'd4);
        check("w_lui_imm", w_imm,      64'hFFFF_FFFF_8000_0000);
        w_in_valid = 1'b0;
        @(negedge clk);
        check("w_idle", 64'(w_out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
